ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Two-requester arbiter and sequencer for the single program/data RAM.
//  Port 0 is the CPU memory stage (fetch/operand/ST); port 1 is the program loader / debug port.
//  Accepts one transaction at a time, drives the RAM's we/waddr/wdata/re/raddr, and returns read data with a one-cycle ack.
//  Round-robin arbitration, with a range check against the implemented RAM depth.
// PARAMETERS
//  ADDR_W      16  address width of requester and RAM ports
//  DATA_W      16  data word width
//  DEPTH_BITS  7   implemented RAM address bits (128 words)
//  CHECK_RANGE 1   1: addr bits above DEPTH_BITS nonzero -> error, no RAM access
// PORTS
//  mclk       in   1       system clock; all state on posedge
//  rst_n      in   1       asynchronous active-low reset
//  req0       in   1       port 0 request; held with we0/addr0/wdata0 stable until ack0
//  we0        in   1       port 0: 1=write, 0=read
//  addr0      in   ADDR_W  port 0 word address
//  wdata0     in   DATA_W  port 0 write data
//  ack0       out  1       port 0 one-cycle completion pulse
//  err0       out  1       port 0 range error, valid with ack0
//  rdata0     out  DATA_W  port 0 read data, valid with ack0
//  req1..rdata1            identical set for port 1
//  ram_we     out  1       RAM write enable (RAM writes on negedge mclk)
//  ram_waddr  out  ADDR_W  RAM write address
//  ram_wdata  out  DATA_W  RAM write data
//  ram_re     out  1       RAM read enable (RAM read path is combinational)
//  ram_raddr  out  ADDR_W  RAM read address
//  ram_rdata  in   DATA_W  RAM read data
//  busy       out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state=IDLE, rr pointer=0 (port 0 preferred). Asserting rst_n mid-transaction aborts it immediately:
//   ram_we drops asynchronously, so no write occurs and no ack is issued.
//  FSM: IDLE -> ACCESS -> DONE -> IDLE. All outputs are registered.
//   IDLE: if any req, grant per rr. Latch we/addr/wdata of the winner, compute range error, go ACCESS.
//   ACCESS (1 cycle): if no error, drive ram_we=we or ram_re=~we, with ram_waddr/ram_raddr=addr and ram_wdata=wdata.
//    The write lands on the mid-cycle negedge. At the closing posedge, ram_rdata is captured into rdata<g> for a read; go DONE.
//   DONE (1 cycle): ack<g>=1, err<g>=error flag, RAM controls 0. Set rr to prefer the other port; go IDLE.
//  Latency: req sampled at posedge k -> ACCESS in cycle k+1 -> ack high during cycle k+2.
//   Max throughput is 1 transaction per 3 cycles.
//  Arbitration: only one req -> it wins. Both req -> the port rr points to wins; the loser stays pending.
//   rr toggles after every completed grant, so the loser wins next.
//  rdata<g> holds its value until the next read completes on that port. A write ack leaves rdata<g> unchanged.
//  Error (CHECK_RANGE=1, addr[ADDR_W-1:DEPTH_BITS]!=0): ram_we/ram_re stay 0; ack with err=1; rdata unchanged.
//  req dropped before ack: the latched transaction still completes and ack still pulses. The protocol forbids this.
//  req held high through ack: treated as a new request in the following IDLE cycle.
//  ram_we and ram_re are never both 1. ack0 and ack1 are never both 1.
// TESTING
//  1. Reset then port 1 writes addr 0x0005 data 0x1210 -> ram_we high exactly 1 cycle, ack1 at k+2, err1=0; RAM[5]=0x1210.
//  2. Port 0 reads 0x0005 after test 1 -> ram_re 1 cycle, ack0 at k+2 with rdata0=0x1210, ram_we stays 0.
//  3. req0 and req1 in the same cycle, both held for 2 transactions -> order: port 0, then port 1.
//   Next simultaneous pair -> port 0 again, since rr toggled after port 1.
//  4. Port 0 write to addr 0x0080 -> no ram_we/ram_re pulse, ack0=1 with err0=1; RAM contents unchanged.
//  5. rst_n low during ACCESS of a write to 0x0010 -> ram_we and outputs 0 immediately, no ack.
//   RAM[0x10] unchanged; after release, IDLE with port 0 preferred.
//  6. Back-to-back port 0 reads at 0x00,0x01 with req held -> acks 3 cycles apart with rdata0 = RAM[0], then RAM[1]; busy low only between them.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - requester and RAM signal bundle for ram_port_arbiter
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic              err0;
  logic [DATA_W-1:0] rdata0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic              err1;
  logic [DATA_W-1:0] rdata1;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  // arbiter side
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_rdata,
    output ack0, err0, rdata0, ack1, err1, rdata1,
    output ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr, busy
  );

  // requesters plus RAM model side
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_rdata,
    input  ack0, err0, rdata0, ack1, err1, rdata1,
    input  ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr, busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin two-port sequencer for the single program/data RAM
module ram_port_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int DEPTH_BITS  = 7,
  parameter int CHECK_RANGE = 1
) (
  input logic               mclk,
  input logic               rst_n,
  ram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic              xerr_q, xerr_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_re_q, ram_re_d;
  logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
  logic [ADDR_W-1:0] ram_raddr_q, ram_raddr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              busy_q, busy_d;

  logic              pick;
  logic              cand_we;
  logic [ADDR_W-1:0] cand_addr;
  logic [DATA_W-1:0] cand_wdata;
  logic              cand_err;

  // Winner selection: a lone request wins; a tie goes to the port rr points at.
  always_comb begin
    pick       = 1'b0;
    cand_we    = 1'b0;
    cand_addr  = '0;
    cand_wdata = '0;
    cand_err   = 1'b0;
    if (bus.req0 && bus.req1) begin
      pick = rr_q;
    end else begin
      pick = bus.req1;
    end
    cand_we    = pick ? bus.we1    : bus.we0;
    cand_addr  = pick ? bus.addr1  : bus.addr0;
    cand_wdata = pick ? bus.wdata1 : bus.wdata0;
    cand_err   = (CHECK_RANGE != 0) && ((cand_addr >> DEPTH_BITS) != '0);
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    xerr_d      = xerr_q;
    ram_we_d    = 1'b0;
    ram_re_d    = 1'b0;
    ram_waddr_d = '0;
    ram_raddr_d = '0;
    ram_wdata_d = '0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err0_d      = 1'b0;
    err1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_d   = pick;
          we_d    = cand_we;
          xerr_d  = cand_err;
          state_d = S_ACCESS;
          if (!cand_err) begin
            ram_we_d    = cand_we;
            ram_re_d    = !cand_we;
            ram_waddr_d = cand_addr;
            ram_raddr_d = cand_addr;
            ram_wdata_d = cand_wdata;
          end
        end
      end
      S_ACCESS: begin
        // RAM read path is combinational, so data is valid at the closing edge.
        if (!xerr_q && !we_q) begin
          if (gnt_q) rdata1_d = bus.ram_rdata;
          else       rdata0_d = bus.ram_rdata;
        end
        ack0_d  = !gnt_q;
        ack1_d  = gnt_q;
        err0_d  = !gnt_q && xerr_q;
        err1_d  = gnt_q && xerr_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        rr_d    = !gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      xerr_q      <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_raddr_q <= '0;
      ram_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      xerr_q      <= xerr_d;
      ram_we_q    <= ram_we_d;
      ram_re_q    <= ram_re_d;
      ram_waddr_q <= ram_waddr_d;
      ram_raddr_q <= ram_raddr_d;
      ram_wdata_q <= ram_wdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ram_we    = ram_we_q;
  assign bus.ram_re    = ram_re_q;
  assign bus.ram_waddr = ram_waddr_q;
  assign bus.ram_raddr = ram_raddr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.err0      = err0_q;
  assign bus.err1      = err1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter with a negedge-write RAM model
module tb_ram_port_arbiter;
  logic mclk  = 1'b0;
  logic rst_n = 1'b0;

  ram_port_arbiter_if bus ();

  ram_port_arbiter dut (
    .mclk  (mclk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 mclk = ~mclk;

  typedef struct {
    int          port;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   we_cnt = 0;
  int   re_cnt = 0;

  logic [15:0] ram [0:127];
  bit          init_done = 1'b0;

  always @(negedge mclk) begin
    if (!init_done) begin
      for (int i = 0; i < 128; i++) ram[i] <= 16'h1000 + 16'(i);
      init_done <= 1'b1;
    end else if (bus.ram_we) begin
      ram[bus.ram_waddr[6:0]] <= bus.ram_wdata;
    end
  end
  assign bus.ram_rdata = ram[bus.ram_raddr[6:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int p, input logic e, input logic [15:0] r);
    exp_t x;
    x.port  = p;
    x.err   = e;
    x.rdata = r;
    sb.push_back(x);
  endtask

  exp_t mon_e;
  int   mon_p;
  always @(negedge mclk) begin
    if (rst_n) begin
      if (bus.ram_we) we_cnt <= we_cnt + 1;
      if (bus.ram_re) re_cnt <= re_cnt + 1;
      if (bus.ram_we || bus.ram_re) chk("we_re_exclusive", 32'(bus.ram_we & bus.ram_re), 0);
      if (bus.ack0 || bus.ack1) begin
        chk("ack_exclusive", 32'(bus.ack0 & bus.ack1), 0);
        if (sb.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          mon_p = bus.ack1 ? 1 : 0;
          chk("ack_port", mon_p, mon_e.port);
          chk("ack_err", 32'(mon_p == 1 ? bus.err1 : bus.err0), 32'(mon_e.err));
          chk("ack_rdata", 32'(mon_p == 1 ? bus.rdata1 : bus.rdata0), 32'(mon_e.rdata));
        end
      end
    end
  end

  task automatic drive(input int p, input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    if (p == 0) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic single(input int p, input logic w, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output logic s_we, output logic s_re, output logic [15:0] s_addr);
    @(negedge mclk);
    drive(p, 1'b1, w, a, d);
    lat = -1; s_we = 1'b0; s_re = 1'b0; s_addr = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge mclk);
      if (i == 1) begin
        s_we   = bus.ram_we;
        s_re   = bus.ram_re;
        s_addr = w ? bus.ram_waddr : bus.ram_raddr;
      end
      if ((p == 0 && bus.ack0) || (p == 1 && bus.ack1)) begin
        lat = i;
        break;
      end
    end
    drive(p, 1'b0, w, a, d);
  endtask

  task automatic pair(input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                      input logic w1, input logic [15:0] a1, input logic [15:0] d1,
                      output int t0, output int t1);
    @(negedge mclk);
    drive(0, 1'b1, w0, a0, d0);
    drive(1, 1'b1, w1, a1, d1);
    t0 = -1; t1 = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge mclk);
      if (bus.ack0 && t0 < 0) begin t0 = i; drive(0, 1'b0, w0, a0, d0); end
      if (bus.ack1 && t1 < 0) begin t1 = i; drive(1, 1'b0, w1, a1, d1); end
      if (t0 > 0 && t1 > 0) break;
    end
    if (t0 < 0) drive(0, 1'b0, w0, a0, d0);
    if (t1 < 0) drive(1, 1'b0, w1, a1, d1);
  endtask

  task automatic do_reset();
    @(negedge mclk);
    rst_n = 1'b0;
    repeat (2) @(negedge mclk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int          lat, t0, t1, ta, tb, busy_low, wb, rb;
    logic        s_we, s_re;
    logic [15:0] s_addr;

    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(negedge mclk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ack0", 32'(bus.ack0), 0);
    chk("rst_ack1", 32'(bus.ack1), 0);
    chk("rst_ram_we", 32'(bus.ram_we), 0);
    chk("rst_ram_re", 32'(bus.ram_re), 0);
    chk("rst_rdata0", 32'(bus.rdata0), 0);
    chk("rst_err1", 32'(bus.err1), 0);
    rst_n = 1'b1;

    // port 1 write 0x1210 to 5
    wb = we_cnt; rb = re_cnt;
    push(1, 1'b0, 16'h0000);
    single(1, 1'b1, 16'h0005, 16'h1210, lat, s_we, s_re, s_addr);
    chk("t1_latency", lat, 2);
    chk("t1_ram_we", 32'(s_we), 1);
    chk("t1_waddr", 32'(s_addr), 32'h5);
    @(negedge mclk);
    chk("t1_we_pulses", we_cnt - wb, 1);
    chk("t1_re_pulses", re_cnt - rb, 0);
    chk("t1_ram5", 32'(ram[5]), 32'h1210);

    // port 0 read back 5
    wb = we_cnt; rb = re_cnt;
    push(0, 1'b0, 16'h1210);
    single(0, 1'b0, 16'h0005, 16'h0000, lat, s_we, s_re, s_addr);
    chk("t2_latency", lat, 2);
    chk("t2_ram_re", 32'(s_re), 1);
    chk("t2_raddr", 32'(s_addr), 32'h5);
    @(negedge mclk);
    chk("t2_we_pulses", we_cnt - wb, 0);
    chk("t2_re_pulses", re_cnt - rb, 1);

    // simultaneous pairs from a fresh rr pointer
    do_reset();
    push(0, 1'b0, 16'h0000);
    push(1, 1'b0, 16'h0000);
    pair(1'b1, 16'h0020, 16'hAAAA, 1'b1, 16'h0021, 16'hBBBB, t0, t1);
    chk("t3a_ack0_cycle", t0, 2);
    chk("t3a_ack1_cycle", t1, 5);
    chk("t3a_ram20", 32'(ram[32]), 32'hAAAA);
    push(0, 1'b0, 16'hBBBB);
    push(1, 1'b0, 16'hAAAA);
    pair(1'b0, 16'h0021, 16'h0000, 1'b0, 16'h0020, 16'h0000, t0, t1);
    chk("t3b_ack0_cycle", t0, 2);
    chk("t3b_ack1_cycle", t1, 5);

    // out-of-range write
    wb = we_cnt; rb = re_cnt;
    push(0, 1'b1, 16'hBBBB);
    single(0, 1'b1, 16'h0080, 16'hDEAD, lat, s_we, s_re, s_addr);
    chk("t4_latency", lat, 2);
    @(negedge mclk);
    chk("t4_we_pulses", we_cnt - wb, 0);
    chk("t4_re_pulses", re_cnt - rb, 0);
    chk("t4_ram0", 32'(ram[0]), 32'h1000);

    // reset during ACCESS of a write
    @(negedge mclk);
    drive(0, 1'b1, 1'b1, 16'h0010, 16'h5555);
    @(posedge mclk);
    #2;
    chk("t5_we_before_rst", 32'(bus.ram_we), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_we_async", 32'(bus.ram_we), 0);
    chk("t5_busy_async", 32'(bus.busy), 0);
    chk("t5_ack0_async", 32'(bus.ack0), 0);
    @(negedge mclk);
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge mclk);
    rst_n = 1'b1;
    @(negedge mclk);
    chk("t5_ram10", 32'(ram[16]), 32'h1010);
    chk("t5_idle", 32'(bus.busy), 0);
    push(0, 1'b0, 16'h1010);
    push(1, 1'b0, 16'h1210);
    pair(1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0005, 16'h0000, t0, t1);
    chk("t5_ack0_cycle", t0, 2);
    chk("t5_ack1_cycle", t1, 5);

    // back-to-back port 0 reads with req held
    push(0, 1'b0, 16'h1000);
    push(0, 1'b0, 16'h1001);
    @(negedge mclk);
    drive(0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    ta = -1; tb = -1; busy_low = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge mclk);
      if (ta > 0 && !bus.busy) busy_low++;
      if (bus.ack0) begin
        if (ta < 0) begin
          ta = i;
          drive(0, 1'b1, 1'b0, 16'h0001, 16'h0000);
        end else begin
          tb = i;
          break;
        end
      end
    end
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("t6_first_ack", ta, 2);
    chk("t6_second_ack", tb, 5);
    chk("t6_busy_low_cycles", busy_low, 1);

    repeat (6) @(negedge mclk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
